// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared constants and state encoding for the period meter
`timescale 1ns/1ps

package period_meter_pkg;

    localparam int unsigned PM_DEF_WIDTH   = 32;
    localparam int unsigned PM_DEF_TIMEOUT = 32'd1000000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pm_state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - two-flop synchroniser with rise/fall pulse detection
`timescale 1ns/1ps

module sig_sync_edge (
    input  logic I_CLK,
    input  logic RST,
    input  logic I_SIG,
    output logic o_rise,
    output logic o_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = I_SIG;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge I_CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_rise = sync2_q & ~prev_q;
    assign o_fall = ~sync2_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow asynchronous square wave
`timescale 1ns/1ps

module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = PM_DEF_WIDTH,
    parameter int unsigned TIMEOUT = PM_DEF_TIMEOUT
) (
    input  logic             I_CLK,
    input  logic             RST,
    input  logic             I_EN,
    input  logic             I_SIG,
    output logic [WIDTH-1:0] O_PERIOD,
    output logic [WIDTH-1:0] O_HIGH,
    output logic             O_VALID,
    output logic             O_TIMEOUT
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic rise, fall;

    pm_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    sig_sync_edge u_sync (
        .I_CLK (I_CLK),
        .RST   (RST),
        .I_SIG (I_SIG),
        .o_rise(rise),
        .o_fall(fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            // Clearing hi_cap makes a fall-less first period report 0
            if (I_EN && rise) begin
                state_d  = MEASURE;
                cnt_d    = ONE_W;
                hi_cap_d = '0;
            end
        end else begin
            if (!I_EN) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (rise) begin
                period_d  = cnt_q;
                high_d    = hi_cap_q;
                valid_d   = 1'b1;
                cnt_d     = ONE_W;
                timeout_d = 1'b0;
            end else if (cnt_q == TIMEOUT_W) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + ONE_W;
                if (fall) begin
                    hi_cap_d = cnt_q;
                end
            end
        end
    end

    always_ff @(posedge I_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign O_PERIOD  = period_q;
    assign O_HIGH    = high_q;
    assign O_VALID   = valid_q;
    assign O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
`timescale 1ns/1ps

module tb_period_meter;

    logic        I_CLK = 1'b0;
    logic        RST   = 1'b0;
    logic        I_EN  = 1'b0;
    logic        I_SIG = 1'b0;
    logic [31:0] O_PERIOD;
    logic [31:0] O_HIGH;
    logic        O_VALID;
    logic        O_TIMEOUT;

    period_meter #(
        .WIDTH  (32),
        .TIMEOUT(100)
    ) dut (
        .I_CLK    (I_CLK),
        .RST      (RST),
        .I_EN     (I_EN),
        .I_SIG    (I_SIG),
        .O_PERIOD (O_PERIOD),
        .O_HIGH   (O_HIGH),
        .O_VALID  (O_VALID),
        .O_TIMEOUT(O_TIMEOUT)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        int hi;
        int lo;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_count = 0;
    int valid_cycle = 0;
    int last_period = 0;
    int last_high = 0;
    int to_cycle = 0;
    bit to_seen = 1'b0;
    bit prev_valid = 1'b0;
    int pre_high = 0;
    int rise_cycle = 0;

    bit async_mode = 1'b0;
    bit async_started = 1'b0;
    int async_first = 0;
    int async_last = 0;
    int async_sum = 0;
    int async_n = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns after every rising edge.
    initial begin
        forever begin
            @(posedge I_CLK);
            #1;
            cyc++;
            if (O_VALID) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_single_pulse at cycle %0d: got 2 consecutive cycles expected 1", cyc);
                end
                valid_count++;
                valid_cycle = cyc;
                last_period = int'(O_PERIOD);
                last_high   = int'(O_HIGH);
                if (async_mode) begin
                    checks++;
                    if (last_period < 9 || last_period > 11) begin
                        errors++;
                        $display("FAIL async_period: got %0d expected 9..11", last_period);
                    end
                    checks++;
                    if (last_high < 3 || last_high > 5) begin
                        errors++;
                        $display("FAIL async_high: got %0d expected 3..5", last_high);
                    end
                    if (async_started) begin
                        async_sum += last_period;
                        async_n++;
                        async_last = cyc;
                    end else begin
                        async_started = 1'b1;
                        async_first = cyc;
                    end
                end
            end
            prev_valid = O_VALID;
            if (O_TIMEOUT && !to_seen) begin
                to_seen = 1'b1;
                to_cycle = cyc;
            end
        end
    end

    // n full periods of I_SIG, then a closing rise held for 3 cycles.
    task automatic run_periods(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            I_SIG = 1'b1;
            repeat (hi - ((p == 0) ? pre_high : 0)) @(negedge I_CLK);
            I_SIG = 1'b0;
            repeat (lo) @(negedge I_CLK);
        end
        I_SIG = 1'b1;
        rise_cycle = cyc;
        repeat (3) @(negedge I_CLK);
        pre_high = 3;
    endtask

    initial begin
        int vc;
        int diff;

        vecs[0] = '{hi: 1,  lo: 1,  exp_period: 2,   exp_high: 1};
        vecs[1] = '{hi: 10, lo: 10, exp_period: 20,  exp_high: 10};
        vecs[2] = '{hi: 3,  lo: 17, exp_period: 20,  exp_high: 3};
        vecs[3] = '{hi: 5,  lo: 5,  exp_period: 10,  exp_high: 5};
        vecs[4] = '{hi: 50, lo: 49, exp_period: 99,  exp_high: 50};
        vecs[5] = '{hi: 60, lo: 40, exp_period: 100, exp_high: 60};

        RST = 1'b0;
        I_EN = 1'b1;
        I_SIG = 1'b0;
        repeat (3) @(negedge I_CLK);
        check("reset_period", int'(O_PERIOD), 0);
        check("reset_high", int'(O_HIGH), 0);
        check("reset_valid", int'(O_VALID), 0);
        check("reset_timeout", int'(O_TIMEOUT), 0);
        RST = 1'b1;
        repeat (2) @(negedge I_CLK);

        pre_high = 0;
        for (int v = 0; v < 6; v++) begin
            vc = valid_count;
            run_periods(vecs[v].hi, vecs[v].lo, 3);
            check($sformatf("vec%0d_valid_count", v), valid_count - vc, 3);
            check($sformatf("vec%0d_period", v), last_period, vecs[v].exp_period);
            check($sformatf("vec%0d_high", v), last_high, vecs[v].exp_high);
            check($sformatf("vec%0d_timeout", v), int'(O_TIMEOUT), 0);
            check($sformatf("vec%0d_latency", v), valid_cycle - rise_cycle, 3);
        end

        // Stall: input stuck low after 20-cycle periods.
        run_periods(10, 10, 3);
        check("stall_pre_period", last_period, 20);
        repeat (7) @(negedge I_CLK);
        I_SIG = 1'b0;
        to_seen = 1'b0;
        for (int i = 0; i < 200 && !to_seen; i++) @(negedge I_CLK);
        check("stall_timeout_seen", int'(to_seen), 1);
        check("stall_timeout_delay", to_cycle - valid_cycle, 100);
        check("stall_period_held", int'(O_PERIOD), 20);
        check("stall_high_held", int'(O_HIGH), 10);
        repeat (20) @(negedge I_CLK);
        check("stall_timeout_sticky", int'(O_TIMEOUT), 1);
        pre_high = 0;
        vc = valid_count;
        run_periods(10, 10, 1);
        check("restart_valid_count", valid_count - vc, 1);
        check("restart_period", last_period, 20);
        check("restart_high", last_high, 10);
        check("restart_timeout_cleared", int'(O_TIMEOUT), 0);

        // Enable dropped for 7 cycles in the low phase.
        vc = valid_count;
        repeat (7) @(negedge I_CLK);
        I_SIG = 1'b0;
        repeat (3) @(negedge I_CLK);
        I_EN = 1'b0;
        repeat (7) @(negedge I_CLK);
        I_EN = 1'b1;
        I_SIG = 1'b1;
        repeat (3) @(negedge I_CLK);
        check("en_gap_no_valid", valid_count - vc, 0);
        pre_high = 3;
        run_periods(10, 10, 1);
        check("en_resume_valid_count", valid_count - vc, 1);
        check("en_resume_period", last_period, 20);
        check("en_resume_high", last_high, 10);
        check("en_resume_latency", valid_cycle - rise_cycle, 3);

        // Short asynchronous reset pulse mid-measurement.
        repeat (7) @(negedge I_CLK);
        I_SIG = 1'b0;
        repeat (4) @(negedge I_CLK);
        #2;
        RST = 1'b0;
        #1;
        check("rst_pulse_period", int'(O_PERIOD), 0);
        check("rst_pulse_high", int'(O_HIGH), 0);
        check("rst_pulse_valid", int'(O_VALID), 0);
        check("rst_pulse_timeout", int'(O_TIMEOUT), 0);
        #1;
        RST = 1'b1;
        repeat (5) @(negedge I_CLK);
        pre_high = 0;
        vc = valid_count;
        run_periods(10, 10, 1);
        check("rst_after_valid_count", valid_count - vc, 1);
        check("rst_after_period", last_period, 20);
        check("rst_after_high", last_high, 10);

        // Asynchronous input: 37 ns high, 63 ns low.
        I_SIG = 1'b0;
        repeat (3) @(negedge I_CLK);
        #3;
        for (int p = 0; p < 52; p++) begin
            if (p == 2) async_mode = 1'b1;
            I_SIG = 1'b1;
            #37;
            I_SIG = 1'b0;
            #63;
        end
        repeat (5) @(negedge I_CLK);
        async_mode = 1'b0;
        check("async_valid_count_ok", int'(async_n >= 45), 1);
        diff = async_sum - (async_last - async_first);
        check("async_sum_vs_elapsed", int'(diff >= -1 && diff <= 1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures an incoming slow square wave, such as the divided clock produced by the team's clock divider, in units of I_CLK cycles.
- Reports the full period and the high time of each cycle.
- Intended as the check-and-display end of the clock-divider labs: the result feeds seven-segment display logic or a self-checking bench.
- Handles an input that is asynchronous to I_CLK and detects when the input has stopped toggling.

Parameters:
- WIDTH, 32, bit width of the internal counter and of both result outputs.
- TIMEOUT, 32'd1000000, number of I_CLK cycles without a rising edge after which the input is declared stalled (must be ≥3 and < 2^WIDTH).

Ports:
- I_CLK  input  1  system clock; all logic is clocked on the rising edge.
- RST  input  1  asynchronous, active-low reset; active when 0.
- I_EN  input  1  measurement enable; when 0 the block idles.
- I_SIG  input  1  signal under measurement; asynchronous to I_CLK.
- O_PERIOD  output  WIDTH  last measured period, in I_CLK cycles.
- O_HIGH  output  WIDTH  last measured high time, in I_CLK cycles.
- O_VALID  output  1  one-cycle pulse when O_PERIOD and O_HIGH update.
- O_TIMEOUT  output  1  sticky stall flag.

Behaviour:
- Reset (RST=0, asynchronous):
  - O_PERIOD=0, O_HIGH=0, O_VALID=0, O_TIMEOUT=0.
  - Counter=0, synchroniser flops=0, state=IDLE.
- Input conditioning:
  - 2-flop synchroniser sync1→sync2, followed by prev<=sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - Latency from an I_SIG edge sampled at clock edge k to the state update is edge k+2.
- States:
  - IDLE: counter held at 0. If I_EN=1 and rise, go to MEASURE with counter<=1.
  - MEASURE: counter increments by 1 each cycle and saturates at TIMEOUT.
    - On fall: hi_cap<=counter.
    - On rise: O_PERIOD<=counter, O_HIGH<=hi_cap, O_VALID<=1 for that cycle, counter<=1, O_TIMEOUT<=0. Stay in MEASURE, so measurement is back-to-back with no lost cycles.
    - If counter==TIMEOUT and no rise in that cycle: O_TIMEOUT<=1, go to IDLE. O_PERIOD and O_HIGH hold their old values.
- Counting convention: the value latched equals the number of I_CLK cycles between successive rise pulses. A divider with mod=20 therefore gives O_PERIOD=20 and O_HIGH=10.
- First period after entering MEASURE: hi_cap is valid only if a fall occurred. If no fall was seen, O_HIGH reports 0; this is impossible for a well-formed input.
- Simultaneous rise and fall in one cycle: impossible by construction, since both derive from the same sync2/prev pair.
- I_EN deasserted mid-measurement:
  - Go to IDLE at the next edge; counter<=0.
  - No O_VALID is produced, and results and O_TIMEOUT are held.
  - Re-enabling waits for a fresh rise, so a partial period is never reported.
- Timeout in IDLE:
  - Not checked.
  - O_TIMEOUT clears only on reset or on the next valid measurement.
- RST asserted mid-measurement: immediate return to reset values. Any pulse in flight is discarded.
- O_VALID is never asserted for two consecutive cycles, because a period is ≥2 cycles after synchronisation.
- Width: the counter never wraps; it saturates at TIMEOUT.

Decomposition:
- Shared package:
  - State encoding constants IDLE=1'b0, MEASURE=1'b1.
  - Default WIDTH and TIMEOUT constants, reused by the divider benches.
- One natural sub-module: sig_sync_edge.
  - Contains the 2-flop synchroniser plus the prev register.
  - Outputs rise and fall pulses; uses I_CLK and RST with the same async active-low reset.
- Everything else lives in period_meter.

Test Plan:
- I_SIG driven by divider mod=20 on the same I_CLK, I_EN=1 → after the second rise, O_VALID pulses once every 20 cycles, with O_PERIOD=20, O_HIGH=10, O_TIMEOUT=0.
- Asynchronous I_SIG with high 37 ns / low 63 ns, 10 ns I_CLK, over 50 periods → each O_PERIOD in {9,10,11}, running sum matches the elapsed cycles ±1, O_HIGH in {3,4,5}.
- TIMEOUT=100, I_SIG stuck at 0 after 3 periods of 20 → O_TIMEOUT=1 exactly 100 cycles after the last counter reload, O_PERIOD stays 20. Restarting I_SIG → next O_VALID reports 20 and clears O_TIMEOUT.
- I_EN dropped for 7 cycles mid-period, then restored → no O_VALID during the gap or for the partial period. The first O_VALID after re-enable comes one full period after the first rise seen while enabled.
- RST pulsed low for 2 ns, off clock edge, mid-MEASURE → all outputs read 0 immediately, no O_VALID until two rises after release.
- Duty-cycle check with I_SIG high 3 / low 17 cycles, synchronous → O_PERIOD=20, O_HIGH=3.
